// File: rtl/ghash_byte_multiplier_pkg.sv
// Shared constants, FSM encoding and helpers for the byte-serial GHASH multiplier.
package ghash_byte_multiplier_pkg;

  // Bits consumed per RUN step and GF(2^128) operand width.
  localparam int NB_BYTE  = 8;
  localparam int NB_BLOCK = 128;

  // Width of one reduction-table entry.
  localparam int NB_RED = 16;

  // Reduction constant for x^128 = 1 + x + x^2 + x^7, GCM bit order (x^0 at the MSB).
  localparam logic [7:0] GF_R = 8'hE1;

  // One RUN step per byte of X.
  localparam int N_STEPS = 16;
  localparam int STEP_W  = $clog2(N_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Reverse the bit order of a byte; turns the outgoing Z byte into a table index.
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j] = v[7-j];
    end
    return r;
  endfunction

endpackage

// File: rtl/ghash_byte_multiplier_gf128_mul_x.sv
// Single multiply-by-x in GF(2^128), GCM bit order: shift toward the LSB and
// fold the outgoing x^127 coefficient back in with the reduction constant.
module gf128_mul_x
  import ghash_byte_multiplier_pkg::*;
#(
  parameter int NB_BLOCK = 128
) (
  input  logic [NB_BLOCK-1:0] i_v,
  output logic [NB_BLOCK-1:0] o_v
);

  logic [NB_BLOCK-1:0] red_term;

  // Reduction polynomial is only added when x^127 overflows out of bit 0.
  always_comb begin
    red_term = '0;
    if (i_v[0]) begin
      red_term = {GF_R, {(NB_BLOCK-8){1'b0}}};
    end
    o_v = (i_v >> 1) ^ red_term;
  end

endmodule

// File: rtl/ghash_byte_multiplier.sv
// Byte-serial GF(2^128) multiplier: Z = X * H in 18 cycles per operand pair.
// PREP builds H*x^0..H*x^7, then 16 RUN steps apply Horner's rule one byte of X
// at a time (highest-degree byte first), reducing the shifted-out Z byte via
// an externally supplied 256-entry table.
module ghash_byte_multiplier #(
  parameter int NB_BYTE  = ghash_byte_multiplier_pkg::NB_BYTE,
  parameter int NB_BLOCK = ghash_byte_multiplier_pkg::NB_BLOCK
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [NB_BLOCK-1:0]         i_x,
  input  logic [NB_BLOCK-1:0]         i_h,
  input  logic [(16<<NB_BYTE)-1:0]    i_r_table,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [NB_BLOCK-1:0]         o_z
);

  import ghash_byte_multiplier_pkg::*;

  state_t               state_q, state_d;
  logic [NB_BLOCK-1:0]  x_q, x_d;
  logic [NB_BLOCK-1:0]  h_q, h_d;
  logic [NB_BLOCK-1:0]  z_q, z_d;
  logic [NB_BLOCK-1:0]  oz_q, oz_d;
  logic [NB_BLOCK-1:0]  hk_q     [NB_BYTE];
  logic [NB_BLOCK-1:0]  hk_d     [NB_BYTE];
  logic [NB_BLOCK-1:0]  hk_chain [NB_BYTE];
  logic [STEP_W-1:0]    step_q, step_d;

  logic                 accept;
  logic [NB_BYTE-1:0]   byte_b;
  logic [NB_BYTE-1:0]   red_idx;
  logic [NB_RED-1:0]    red_entry;
  logic [NB_BLOCK-1:0]  partial;
  logic [NB_BLOCK-1:0]  z_step;

  // H*x^k chain: H_0 is H itself, each further stage multiplies by x once more.
  assign hk_chain[0] = h_q;

  generate
    for (genvar gi = 1; gi < NB_BYTE; gi++) begin : g_mul_x
      gf128_mul_x #(
        .NB_BLOCK (NB_BLOCK)
      ) u_mul_x (
        .i_v (hk_chain[gi-1]),
        .o_v (hk_chain[gi])
      );
    end
  endgenerate

  // One Horner step: Z*x^8 with table reduction, plus the current byte times H.
  always_comb begin
    byte_b    = x_q[NB_BYTE*int'(step_q) +: NB_BYTE];
    red_idx   = bit_rev8(z_q[7:0]);
    red_entry = i_r_table[NB_RED*int'(red_idx) +: NB_RED];
    partial   = '0;
    for (int k = 0; k < NB_BYTE; k++) begin
      if (byte_b[NB_BYTE-1-k]) begin
        partial = partial ^ hk_q[k];
      end
    end
    z_step = (z_q >> NB_BYTE) ^ {red_entry, {(NB_BLOCK-NB_RED){1'b0}}} ^ partial;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
        if (i_valid) state_d = ST_PREP;
      end
      ST_PREP: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_ready = 1'b1;
        o_valid = 1'b1;
        accept  = i_valid;
        state_d = i_valid ? ST_PREP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: capture operands on accept, build H_k in PREP, step Z in RUN.
  always_comb begin
    x_d    = x_q;
    h_d    = h_q;
    z_d    = z_q;
    oz_d   = oz_q;
    step_d = step_q;
    for (int k = 0; k < NB_BYTE; k++) begin
      hk_d[k] = hk_q[k];
    end
    if (accept) begin
      x_d    = i_x;
      h_d    = i_h;
      z_d    = '0;
      step_d = '0;
    end
    if (state_q == ST_PREP) begin
      for (int k = 0; k < NB_BYTE; k++) begin
        hk_d[k] = hk_chain[k];
      end
    end
    if (state_q == ST_RUN) begin
      z_d    = z_step;
      step_d = step_q + STEP_W'(1);
      if (step_q == LAST_STEP) begin
        oz_d = z_step;
      end
    end
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      h_q     <= '0;
      z_q     <= '0;
      oz_q    <= '0;
      step_q  <= '0;
      for (int k = 0; k < NB_BYTE; k++) begin
        hk_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      h_q     <= h_d;
      z_q     <= z_d;
      oz_q    <= oz_d;
      step_q  <= step_d;
      for (int k = 0; k < NB_BYTE; k++) begin
        hk_q[k] <= hk_d[k];
      end
    end
  end

  assign o_z = oz_q;

endmodule

// File: tb/tb_ghash_byte_multiplier.sv
// Directed and random checks of the byte-serial GHASH multiplier against a
// bit-serial GF(2^128) reference.
module tb_ghash_byte_multiplier;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [127:0]  i_x;
  logic [127:0]  i_h;
  logic [4095:0] r_table;
  logic          o_ready;
  logic          o_valid;
  logic [127:0]  o_z;

  int n_vec = 0;
  int n_err = 0;

  // Cycles from accepting edge to the edge raising o_valid: PREP (1) + RUN (16).
  // Counting the accepting edge itself as edge 1, o_valid rises on edge 18.
  localparam int LAT = 17;

  always #5 clk = ~clk;

  ghash_byte_multiplier dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_valid   (i_valid),
    .i_x       (i_x),
    .i_h       (i_h),
    .i_r_table (r_table),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_z       (o_z)
  );

  // Textbook bit-serial GCM multiply.
  function automatic logic [127:0] gf_ref(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'b0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, then wait (bounded) for o_valid; lat counts edges after acceptance.
  task automatic run_op(input logic [127:0] x, input logic [127:0] h,
                        output logic [127:0] z, output int lat);
    i_x     = x;
    i_h     = h;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      tick();
      lat++;
    end
    z = o_z;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_x     = 128'h1;
    i_h     = 128'h1;
    tick();
    tick();
    n_vec++;
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_vec++;
    if (o_z !== 128'h0) begin n_err++; $display("FAIL reset_z: got %h expected 0", o_z); end
    i_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic test_zero_x();
    logic [127:0] z;
    int lat;
    run_op(128'h0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, z, lat);
    n_vec++;
    if (lat !== LAT) begin n_err++; $display("FAIL zero_x_latency: got %0d expected %0d", lat, LAT); end
    n_vec++;
    if (z !== 128'h0) begin n_err++; $display("FAIL zero_x_z: got %h expected 0", z); end
  endtask

  task automatic test_kat();
    logic [127:0] z;
    int lat;
    run_op(128'h0388dace60b6a392f328c2b971b2fe78, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, z, lat);
    n_vec++;
    if (lat !== LAT) begin n_err++; $display("FAIL kat_latency: got %0d expected %0d", lat, LAT); end
    n_vec++;
    if (z !== 128'h5e2ec746917062882c85b0685353deb7) begin
      n_err++; $display("FAIL kat_z: got %h expected 5e2ec746917062882c85b0685353deb7", z);
    end
    tick();
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL kat_strobe_width: got %b expected 0", o_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (o_z !== 128'h5e2ec746917062882c85b0685353deb7) begin
        n_err++; $display("FAIL kat_hold: got %h expected 5e2ec746917062882c85b0685353deb7", o_z);
      end
    end
  endtask

  task automatic test_one_h();
    logic [127:0] z;
    logic [127:0] x;
    int lat;
    for (int i = 0; i < 3; i++) begin
      x = rnd128();
      run_op(x, {1'b1, 127'b0}, z, lat);
      n_vec++;
      if (z !== x) begin n_err++; $display("FAIL one_h_z: got %h expected %h", z, x); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] x1, h1, x2, h2, e1, e2;
    int t1, t2, ready_seen;
    x1 = rnd128(); h1 = rnd128();
    x2 = rnd128(); h2 = rnd128();
    e1 = gf_ref(x1, h1);
    e2 = gf_ref(x2, h2);
    i_x = x1; i_h = h1; i_valid = 1'b1;
    tick();
    // Keep i_valid up with junk operands through PREP/RUN; they must be ignored.
    i_x = rnd128(); i_h = rnd128();
    t1 = 0; ready_seen = 0;
    while (!o_valid && t1 < 40) begin
      tick();
      t1++;
      if (o_ready && !o_valid) ready_seen++;
    end
    n_vec++;
    if (t1 !== LAT) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected %0d", t1, LAT); end
    n_vec++;
    if (ready_seen !== 0) begin n_err++; $display("FAIL b2b_busy_ready: got %0d ready cycles expected 0", ready_seen); end
    n_vec++;
    if (o_z !== e1) begin n_err++; $display("FAIL b2b_first_z: got %h expected %h", o_z, e1); end
    // Second pair offered in the DONE cycle.
    i_x = x2; i_h = h2;
    tick();
    i_valid = 1'b0;
    t2 = 0;
    while (!o_valid && t2 < 40) begin
      tick();
      t2++;
    end
    n_vec++;
    if (t2 + 1 !== 18) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 18", t2 + 1); end
    n_vec++;
    if (o_z !== e2) begin n_err++; $display("FAIL b2b_second_z: got %h expected %h", o_z, e2); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] x, h, z, e;
    int lat, strobes;
    x = rnd128(); h = rnd128();
    i_x = x; i_h = h; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (8) tick();  // now in RUN at step 7
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", o_ready); end
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
    n_vec++;
    if (o_z !== 128'h0) begin n_err++; $display("FAIL midrst_z: got %h expected 0", o_z); end
    tick();
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (o_valid) strobes++;
    end
    n_vec++;
    if (strobes !== 0) begin n_err++; $display("FAIL midrst_no_strobe: got %0d strobes expected 0", strobes); end
    x = rnd128(); h = rnd128();
    e = gf_ref(x, h);
    run_op(x, h, z, lat);
    n_vec++;
    if (lat !== LAT) begin n_err++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
    n_vec++;
    if (z !== e) begin n_err++; $display("FAIL midrst_z_after: got %h expected %h", z, e); end
  endtask

  task automatic test_random();
    logic [127:0] x, h, z, e;
    int lat;
    for (int n = 0; n < 500; n++) begin
      x = rnd128(); h = rnd128();
      e = gf_ref(x, h);
      run_op(x, h, z, lat);
      n_vec++;
      if (lat !== LAT || z !== e) begin
        n_err++;
        $display("FAIL random_%0d: got z=%h lat=%0d expected z=%h lat=%0d", n, z, lat, e, LAT);
      end
    end
  endtask

  initial begin
    logic [15:0] ent;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_x     = '0;
    i_h     = '0;
    for (int n = 0; n < 256; n++) begin
      ent = 16'h0;
      for (int j = 0; j < 8; j++) begin
        if (((n >> j) & 1) != 0) ent = ent ^ (16'hE100 >> j);
      end
      r_table[16*n +: 16] = ent;
    end
    test_reset();
    test_zero_x();
    test_kat();
    test_one_h();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ghash_byte_multiplier.md
GHASH_BYTE_MULTIPLIER -- requirements
Module: ghash_byte_multiplier

Interface
REQ-001 Parameter NB_BYTE, default 8, SHALL set bits per processing step.
REQ-002 Parameter NB_BLOCK, default 128, SHALL set the GF(2^128) operand width.
REQ-003 i_clock  input  1  SHALL be the single clock; every register SHALL be clocked on its rising edge.
REQ-004 i_reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_valid  input  1  SHALL qualify i_x and i_h.
REQ-006 i_x  input  128  SHALL be the data operand, GCM bit order ([127] = x^0).
REQ-007 i_h  input  128  SHALL be the hash key operand, GCM bit order.
REQ-008 i_r_table  input  4096  SHALL be the 256-entry, 16-bit reduction table; entry n occupies [16n+:16], and bit j of n contributes 16'hE100>>j.
REQ-009 o_ready  output  1  SHALL flag that an operand pair can be accepted.
REQ-010 o_valid  output  1  SHALL be a one-cycle strobe qualifying o_z.
REQ-011 o_z  output  128  SHALL be the product X·H in GF(2^128), GCM bit order.

Function
REQ-012 FSM states SHALL be IDLE, PREP, RUN and DONE.
REQ-013 o_ready SHALL be 1 in IDLE and DONE and 0 in PREP and RUN.
REQ-014 On an edge with i_valid=1 and o_ready=1, the block SHALL register X and H, clear Z and go to PREP.
REQ-015 i_valid while o_ready=0 SHALL be ignored with no side effects.
REQ-016 PREP SHALL last one cycle and register H_k = H·x^k for k=0..7, where each ·x is a right shift by 1 that XORs 8'hE1 into [127:120] when the shifted-out bit [0] was 1.
REQ-017 RUN SHALL last exactly 16 cycles, counted by a 4-bit step counter i = 0..15.
REQ-018 RUN step i SHALL take byte b = X[8i+:8] (step 0 uses X[7:0], the highest degree).
REQ-019 Each RUN step SHALL compute Z' = (Z>>8) XOR {R[rev(Z[7:0])], 112'b0} XOR P, where rev is 8-bit bit reversal and R is the i_r_table entry.
REQ-020 P SHALL be the XOR over k=0..7 of H_k gated by b[7-k].
REQ-021 After step 15 the FSM SHALL enter DONE, drive o_valid=1 for exactly that cycle and load o_z with Z'.
REQ-022 Latency SHALL be 18 clock edges from the accepting edge to the edge that raises o_valid.
REQ-023 DONE SHALL return to IDLE, or to PREP if a new pair is accepted in DONE, giving one result per 18 cycles back-to-back.
REQ-024 o_z SHALL hold its value until the next o_valid.
REQ-025 i_r_table SHALL be sampled combinationally in RUN only, and SHALL be stable from the accepting edge to o_valid.

Reset
REQ-026 Assertion of i_reset SHALL immediately force state IDLE, o_valid=0, o_ready=1, o_z=0, and clear X, H, H_k, Z and the step counter.
REQ-027 A reset asserted mid-operation SHALL abort the operation with no o_valid; the first post-reset acceptance SHALL behave as a fresh operation.

Structure
REQ-028 A shared package SHALL hold NB_BYTE, NB_BLOCK, the reduction constant 8'hE1, the FSM state encodings and the 16-step count.
REQ-029 A single-bit ·x reduction SHALL be a sub-module gf128_mul_x, instanced seven times to build H_1..H_7.

Verification
REQ-030 X=0, any H -> o_z=0, 18 edges after acceptance.
REQ-031 H=128'h8000...0 (one), X random -> o_z=X.
REQ-032 X=128'h0388dace60b6a392f328c2b971b2fe78 and H=128'h66e94bd4ef8a2c3b884cfa59ca342b2e -> o_z=128'h5e2ec746917062882c85b0685353deb7.
REQ-033 Two pairs, the second presented in the DONE cycle -> two o_valid strobes 18 cycles apart, each matching a bit-serial reference model; i_valid held during RUN -> no extra acceptance.
REQ-034 Reset asserted at RUN step 7 -> outputs cleared at once, no o_valid, and the next operation's result is correct.
REQ-035 500 random X and H pairs with a correctly generated i_r_table -> every o_z matches the bit-serial GF(2^128) model.
